inflight_issue_gate: RTL and testbench

- Per-wavefront issue-eligibility gate in the issue stage.
- Consumes the no-inflight/max-inflight flags from the per-wavefront inflight instruction counters.
- Produces the can_issue mask that feeds the issue arbiter.
- Throttles wavefronts at the inflight limit and serialises drain-type instructions (barrier, branch, s_waitcnt 0): each waits for an empty pipeline, issues alone, and blocks its wavefront until it retires.

---
 rtl/inflight_issue_gate.sv | 106 ++++++++++
 tb/tb_inflight_issue_gate.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inflight_issue_gate.sv
// Per-wavefront issue-eligibility gate: throttles wavefronts at the inflight
// limit and serialises drain-type instructions around an empty pipeline.
module inflight_issue_gate #(
    parameter int NUM_WF  = 40,
    parameter int WF_ID_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_WF-1:0]  ready_in,
    input  logic [NUM_WF-1:0]  drain_req,
    input  logic [NUM_WF-1:0]  no_inflight_instr_flag,
    input  logic [NUM_WF-1:0]  max_inflight_instr_flag,
    input  logic               issued_en,
    input  logic [WF_ID_W-1:0] issued_wf_id,
    input  logic               flush_en,
    input  logic [WF_ID_W-1:0] flush_wf_id,
    output logic [NUM_WF-1:0]  can_issue,
    output logic [NUM_WF-1:0]  draining,
    output logic [CNT_W-1:0]   drain_stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        EXCL  = 2'd2
    } wf_state_t;

    logic [NUM_WF-1:0] issue_violation;

    for (genvar w = 0; w < NUM_WF; w++) begin : g_wf
        wf_state_t state_q;
        wf_state_t state_d;
        logic      issue_hit;
        logic      flush_hit;
        logic      eligible;

        // Out-of-range ids never compare equal to any wavefront index.
        assign issue_hit = issued_en && (issued_wf_id == WF_ID_W'(w));
        assign flush_hit = flush_en && (flush_wf_id == WF_ID_W'(w));

        always_comb begin
            // NOTE: every always_comb output gets a default first so no latch is inferred.
            eligible = 1'b0;
            if (state_q == IDLE) begin
                if (drain_req[w])
                    eligible = ready_in[w] & no_inflight_instr_flag[w];
                else
                    eligible = ready_in[w] & ~max_inflight_instr_flag[w];
            end
        end

        always_comb begin
            state_d = state_q;
            if (flush_hit) begin
                state_d = IDLE;
            end else if (issue_hit && !eligible) begin
                state_d = state_q;   // illegal issue: hold, the assertion reports it
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (issue_hit && drain_req[w])
                            state_d = EXCL;
                        else if (ready_in[w] && drain_req[w] && !no_inflight_instr_flag[w])
                            state_d = DRAIN;
                    end
                    DRAIN: begin
                        if (!ready_in[w] || no_inflight_instr_flag[w])
                            state_d = IDLE;
                    end
                    EXCL: begin
                        if (no_inflight_instr_flag[w])
                            state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (rst)
                state_q <= IDLE;
            else
                state_q <= state_d;
        end

        assign can_issue[w]       = eligible;
        assign draining[w]        = (state_q == DRAIN);
        assign issue_violation[w] = issue_hit & ~eligible;
    end

    // Counts cycles where at least one wavefront is waiting for its pipeline to empty.
    always_ff @(posedge clk) begin
        if (rst)
            drain_stall_count <= '0;
        else if ((|draining) && (drain_stall_count != {CNT_W{1'b1}}))
            drain_stall_count <= drain_stall_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (issue_violation == '0);
    end

endmodule

// File: tb/tb_inflight_issue_gate.sv
// Self-checking bench for inflight_issue_gate: vector table, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_inflight_issue_gate;

    localparam int NUM_WF  = 40;
    localparam int WF_ID_W = 6;
    localparam int CNT_W   = 16;
    localparam int SAT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_WF-1:0]  ready_in, drain_req, no_inflight, max_flag;
    logic               issued_en, flush_en;
    logic [WF_ID_W-1:0] issued_wf_id, flush_wf_id;
    logic [NUM_WF-1:0]  can_issue, draining, can_issue_s, draining_s;
    logic [CNT_W-1:0]   cnt;
    logic [SAT_W-1:0]   cnt_s;

    always #5 clk = ~clk;

    inflight_issue_gate #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ready_in(ready_in), .drain_req(drain_req),
        .no_inflight_instr_flag(no_inflight), .max_inflight_instr_flag(max_flag),
        .issued_en(issued_en), .issued_wf_id(issued_wf_id),
        .flush_en(flush_en), .flush_wf_id(flush_wf_id),
        .can_issue(can_issue), .draining(draining), .drain_stall_count(cnt)
    );

    inflight_issue_gate #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .ready_in(ready_in), .drain_req(drain_req),
        .no_inflight_instr_flag(no_inflight), .max_inflight_instr_flag(max_flag),
        .issued_en(issued_en), .issued_wf_id(issued_wf_id),
        .flush_en(flush_en), .flush_wf_id(flush_wf_id),
        .can_issue(can_issue_s), .draining(draining_s), .drain_stall_count(cnt_s)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: which wavefronts wait on a drain, which own the pipeline.
    logic [NUM_WF-1:0] m_wait, m_excl;
    int                m_cnt, m_cnt_s;

    typedef struct {
        int   wf;
        logic ready;
        logic drain;
        logic noinf;
        logic maxf;
        logic exp_can;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_WF-1:0] model_can();
        logic [NUM_WF-1:0] c = '0;
        for (int w = 0; w < NUM_WF; w++) begin
            if (!m_wait[w] && !m_excl[w] && ready_in[w])
                c[w] = drain_req[w] ? no_inflight[w] : !max_flag[w];
        end
        return c;
    endfunction

    task automatic model_edge();
        logic [NUM_WF-1:0] can;
        bit is_hit, fl_hit;
        can = model_can();
        if (rst) begin
            m_wait = '0; m_excl = '0; m_cnt = 0; m_cnt_s = 0;
            return;
        end
        if (m_wait != '0) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_cnt_s < (1 << SAT_W) - 1) m_cnt_s++;
        end
        for (int w = 0; w < NUM_WF; w++) begin
            is_hit = issued_en && (int'(issued_wf_id) == w);
            fl_hit = flush_en && (int'(flush_wf_id) == w);
            if (fl_hit) begin
                m_wait[w] = 1'b0; m_excl[w] = 1'b0;
            end else if (is_hit && !can[w]) begin
                // illegal issue leaves the wavefront untouched
            end else if (m_wait[w]) begin
                if (!ready_in[w] || no_inflight[w]) m_wait[w] = 1'b0;
            end else if (m_excl[w]) begin
                if (no_inflight[w]) m_excl[w] = 1'b0;
            end else if (is_hit && drain_req[w]) begin
                m_excl[w] = 1'b1;
            end else if (ready_in[w] && drain_req[w] && !no_inflight[w]) begin
                m_wait[w] = 1'b1;
            end
        end
    endtask

    task automatic set_defaults();
        ready_in = '0; drain_req = '0; no_inflight = '1; max_flag = '0;
        issued_en = 1'b0; issued_wf_id = '0; flush_en = 1'b0; flush_wf_id = '0;
    endtask

    // Compare everything against the model, then advance one clock.
    task automatic tick();
        #1;
        check("can_issue", 64'(can_issue), 64'(model_can()));
        check("draining", 64'(draining), 64'(m_wait));
        check("stall_count", 64'(cnt), 64'(m_cnt));
        check("sat_count", 64'(cnt_s), 64'(m_cnt_s));
        check("sat_draining", 64'(draining_s), 64'(m_wait));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{39, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{39, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{39, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{39, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{39, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{39, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{39, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{39, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{39, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        set_defaults();
        rst = 1'b1;
        m_wait = '0; m_excl = '0; m_cnt = 0; m_cnt_s = 0;
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        check("reset_can_issue", 64'(can_issue), 64'd0);
        check("reset_draining", 64'(draining), 64'd0);
        check("reset_count", 64'(cnt), 64'd0);

        // Combinational eligibility table; inputs are idled before each edge.
        foreach (vecs[i]) begin
            set_defaults();
            ready_in[vecs[i].wf]    = vecs[i].ready;
            drain_req[vecs[i].wf]   = vecs[i].drain;
            no_inflight[vecs[i].wf] = vecs[i].noinf;
            max_flag[vecs[i].wf]    = vecs[i].maxf;
            #1;
            check("table_can", 64'(can_issue[vecs[i].wf]), 64'(vecs[i].exp_can));
            set_defaults();
            tick();
        end

        // Throttle at the inflight limit, release in the same cycle.
        set_defaults();
        ready_in[0] = 1'b1; no_inflight[0] = 1'b0; max_flag[0] = 1'b1;
        #1;
        check("throttle_blocked", 64'(can_issue[0]), 64'd0);
        max_flag[0] = 1'b0;
        #1;
        check("throttle_release", 64'(can_issue[0]), 64'd1);
        set_defaults();
        tick();

        // Drain entry: four DRAIN cycles, then eligible.
        set_defaults();
        ready_in[2] = 1'b1; drain_req[2] = 1'b1; no_inflight[2] = 1'b0;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) no_inflight[2] = 1'b1;
            #1;
            check("drain_active", 64'(draining[2]), 64'd1);
            check("drain_blocked", 64'(can_issue[2]), 64'd0);
            tick();
        end
        #1;
        check("drain_exit", 64'(draining[2]), 64'd0);
        check("drain_can_issue", 64'(can_issue[2]), 64'd1);
        check("drain_count", 64'(cnt), 64'd4);

        // Exclusive issue: blocked until the pipeline is empty again.
        issued_en = 1'b1; issued_wf_id = WF_ID_W'(2);
        tick();
        for (int k = 1; k <= 4; k++) begin
            issued_en = 1'b0;
            drain_req[2] = 1'b0;
            no_inflight[2] = (k == 4);
            #1;
            check("excl_blocked", 64'(can_issue[2]), 64'd0);
            check("excl_not_draining", 64'(draining[2]), 64'd0);
            tick();
        end
        #1;
        check("excl_release", 64'(can_issue[2]), 64'd1);
        set_defaults();
        tick();

        // Flush beats a same-cycle drain issue; out-of-range flush is ignored.
        ready_in[7] = 1'b1; drain_req[7] = 1'b1;
        issued_en = 1'b1; issued_wf_id = WF_ID_W'(7);
        flush_en = 1'b1; flush_wf_id = WF_ID_W'(7);
        tick();
        issued_en = 1'b0; flush_en = 1'b0;
        #1;
        check("flush_over_issue", 64'(can_issue[7]), 64'd1);
        no_inflight[7] = 1'b0;
        tick();
        flush_en = 1'b1; flush_wf_id = WF_ID_W'(45);
        tick();
        #1;
        check("oor_flush_ignored", 64'(draining[7]), 64'd1);
        flush_wf_id = WF_ID_W'(7);
        tick();
        flush_en = 1'b0;
        #1;
        check("flush_drain", 64'(draining[7]), 64'd0);
        set_defaults();
        tick();

        // Reset in the middle of an EXCL and a DRAIN.
        set_defaults();
        ready_in[3] = 1'b1; drain_req[3] = 1'b1;
        issued_en = 1'b1; issued_wf_id = WF_ID_W'(3);
        ready_in[5] = 1'b1; drain_req[5] = 1'b1; no_inflight[5] = 1'b0;
        tick();
        issued_en = 1'b0; no_inflight[3] = 1'b0;
        #1;
        check("midop_drain5", 64'(draining[5]), 64'd1);
        check("midop_excl3", 64'(can_issue[3]), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drain_req[3] = 1'b0; ready_in[5] = 1'b0;
        #1;
        check("midop_rst_draining", 64'(draining), 64'd0);
        check("midop_rst_count", 64'(cnt), 64'd0);
        check("midop_rst_wf3_idle", 64'(can_issue[3]), 64'd1);
        set_defaults();
        tick();

        // Saturation of the narrow counter.
        ready_in[1] = 1'b1; drain_req[1] = 1'b1; no_inflight[1] = 1'b0;
        repeat (21) tick();
        #1;
        check("sat_stops", 64'(cnt_s), 64'd15);
        check("wide_count", 64'(cnt), 64'd20);
        set_defaults();
        tick();

        // Randomized traffic against the model; only legal issues are driven.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NUM_WF-1:0] can;
            int r, start;
            set_defaults();
            rst = ($urandom_range(0, 199) == 0);
            for (int w = 0; w < NUM_WF; w++) begin
                ready_in[w]  = ($urandom_range(0, 3) != 0);
                drain_req[w] = ($urandom_range(0, 4) == 0);
                r = $urandom_range(0, 19);
                no_inflight[w] = (r < 10) || (r == 19);
                max_flag[w]    = ((r >= 10) && (r < 13)) || (r == 19);
            end
            can = model_can();
            if ((can != '0) && ($urandom_range(0, 9) < 7)) begin
                start = $urandom_range(0, NUM_WF - 1);
                for (int k = 0; k < NUM_WF; k++) begin
                    if (!issued_en && can[(start + k) % NUM_WF]) begin
                        issued_en = 1'b1;
                        issued_wf_id = WF_ID_W'((start + k) % NUM_WF);
                    end
                end
            end
            if ($urandom_range(0, 19) == 0) begin
                flush_en = 1'b1;
                flush_wf_id = WF_ID_W'($urandom_range(0, 63));
            end
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
